// File: rtl/addr_gen_pkg.sv
// Shared types and default sizes for the address request issuer.
package addr_gen_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } issuer_state_e;

   localparam int DEFAULT_DEPTH = 8;
   localparam int DEFAULT_AW    = 32;

endpackage

// File: rtl/addr_req_issuer_if.sv
// Memory read request handshake: valid/ready with the address carried alongside.
interface addr_req_issuer_if #(
   parameter int AW = addr_gen_pkg::DEFAULT_AW
);
   logic          req_valid;
   logic          req_ready;
   logic [AW-1:0] req_addr;

   modport master (output req_valid, output req_addr, input req_ready);
   modport slave  (input req_valid, input req_addr, output req_ready);
endinterface

// File: rtl/addr_fifo.sv
// Synchronous FIFO with registered occupancy; a push into a full FIFO is taken
// when a pop happens on the same edge.
module addr_fifo #(
   parameter int DEPTH = addr_gen_pkg::DEFAULT_DEPTH,
   parameter int W     = addr_gen_pkg::DEFAULT_AW
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         flush,
   input  logic         push,
   input  logic [W-1:0] din,
   input  logic         pop,
   output logic         full,
   output logic         empty,
   output logic [W-1:0] head
);
   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = PW + 1;

   logic [W-1:0]  mem [DEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic [CW-1:0] count;
   logic          do_push;
   logic          do_pop;

   assign full    = (count == CW'(DEPTH));
   assign empty   = (count == '0);
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign head    = mem[rd_ptr];

   // Storage is not reset; the empty flag guards every read of it.
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= din;
      end
   end

   always_ff @(posedge clk) begin
      if (rst || flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + PW'(1);
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + PW'(1);
         end
         unique case ({do_push, do_pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/addr_req_issuer.sv
// Captures a run of free-running addresses into a FIFO and issues them as memory
// read requests. Optional ADDR_REQ_BOUNDS_CHECK_EN adds addr_limit/bounds_err.
//
// state | meaning
// IDLE  | after reset, waiting for start
// RUN   | capturing one in_addr per cycle until num_reqs are taken
// DRAIN | capture finished, issuing what is left in the FIFO
// DONE  | FIFO empty, run complete, waiting for start
module addr_req_issuer
   import addr_gen_pkg::*;
#(
   parameter int DEPTH = DEFAULT_DEPTH,
   parameter int AW    = DEFAULT_AW
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic [31:0]   num_reqs,
   input  logic [AW-1:0] in_addr,
`ifdef ADDR_REQ_BOUNDS_CHECK_EN
   input  logic [AW-1:0] addr_limit,
   output logic          bounds_err,
`endif
   addr_req_issuer_if.master req,
   output logic          busy,
   output logic          done,
   output logic          overflow,
   output logic [31:0]   issued_cnt
);
   issuer_state_e state;
   logic [31:0]   remain;
   logic          start_ok;
   logic          capture;
   logic          in_bounds;
   logic          push_req;
   logic          pop;
   logic          fifo_push;
   logic          drop;
   logic          fifo_full;
   logic          fifo_empty;
   logic [AW-1:0] fifo_head;

`ifdef ADDR_REQ_BOUNDS_CHECK_EN
   logic [AW-1:0] limit_q;
   assign in_bounds = (in_addr < limit_q);
`else
   assign in_bounds = 1'b1;
`endif

   assign start_ok  = start && ((state == IDLE) || (state == DONE));
   assign capture   = (state == RUN);
   assign push_req  = capture && in_bounds;
   assign pop       = req.req_valid && req.req_ready;
   assign fifo_push = push_req && (!fifo_full || pop);
   assign drop      = push_req && fifo_full && !pop;

   assign req.req_valid = !fifo_empty;
   assign req.req_addr  = fifo_empty ? '0 : fifo_head;

   addr_fifo #(
      .DEPTH (DEPTH),
      .W     (AW)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .flush (start_ok),
      .push  (fifo_push),
      .din   (in_addr),
      .pop   (pop),
      .full  (fifo_full),
      .empty (fifo_empty),
      .head  (fifo_head)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         remain     <= '0;
         busy       <= 1'b0;
         done       <= 1'b0;
         overflow   <= 1'b0;
         issued_cnt <= '0;
`ifdef ADDR_REQ_BOUNDS_CHECK_EN
         limit_q    <= '0;
         bounds_err <= 1'b0;
`endif
      end else begin
         if (pop) begin
            issued_cnt <= issued_cnt + 32'd1;
         end
         if (drop) begin
            overflow <= 1'b1;
         end
`ifdef ADDR_REQ_BOUNDS_CHECK_EN
         if (capture && !in_bounds) begin
            bounds_err <= 1'b1;
         end
`endif
         unique case (state)
            IDLE, DONE: begin
               if (start) begin
                  remain     <= num_reqs;
                  issued_cnt <= '0;
                  overflow   <= 1'b0;
`ifdef ADDR_REQ_BOUNDS_CHECK_EN
                  limit_q    <= addr_limit;
                  bounds_err <= 1'b0;
`endif
                  if (num_reqs == '0) begin
                     state <= DONE;
                     busy  <= 1'b0;
                     done  <= 1'b1;
                  end else begin
                     state <= RUN;
                     busy  <= 1'b1;
                     done  <= 1'b0;
                  end
               end
            end
            RUN: begin
               // remain counts down; the last capture is the one taken at 1.
               remain <= remain - 32'd1;
               if (remain == 32'd1) begin
                  state <= DRAIN;
               end
            end
            DRAIN: begin
               if (fifo_empty) begin
                  state <= DONE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
               end
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
               done  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_addr_req_issuer.sv
// Scoreboard bench for addr_req_issuer: expected addresses are queued as they
// are captured and checked in order as requests are accepted.
module tb_addr_req_issuer;
   localparam int AW    = 32;
   localparam int DEPTH = 8;

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic [31:0]   num_reqs;
   logic [AW-1:0] in_addr;
   logic          busy;
   logic          done;
   logic          overflow;
   logic [31:0]   issued_cnt;
`ifdef ADDR_REQ_BOUNDS_CHECK_EN
   logic [AW-1:0] addr_limit;
   logic          bounds_err;
`endif

   int errors = 0;
   int checks = 0;
   logic [AW-1:0] exp_q[$];
   logic [AW-1:0] exp_a;

   addr_req_issuer_if #(.AW(AW)) req_if ();

   addr_req_issuer #(
      .DEPTH (DEPTH),
      .AW    (AW)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .num_reqs   (num_reqs),
      .in_addr    (in_addr),
`ifdef ADDR_REQ_BOUNDS_CHECK_EN
      .addr_limit (addr_limit),
      .bounds_err (bounds_err),
`endif
      .req        (req_if.master),
      .busy       (busy),
      .done       (done),
      .overflow   (overflow),
      .issued_cnt (issued_cnt)
   );

   always #5 clk = ~clk;

   // Every accepted request must match the oldest captured address.
   always @(negedge clk) begin
      if (rst === 1'b0 && req_if.req_valid === 1'b1 && req_if.req_ready === 1'b1) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL issue_order: unexpected request addr=%h with nothing expected", req_if.req_addr);
         end else begin
            exp_a = exp_q.pop_front();
            if (req_if.req_addr !== exp_a) begin
               errors++;
               $display("FAIL issue_order: got addr=%h want %h", req_if.req_addr, exp_a);
            end
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
      in_addr = in_addr + 32'd1;
   endtask

   task automatic do_start(input logic [31:0] n);
      start    = 1'b1;
      num_reqs = n;
      step();
      start    = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      start = 1'b0;
      num_reqs = '0;
      in_addr = '0;
      req_if.req_ready = 1'b0;
`ifdef ADDR_REQ_BOUNDS_CHECK_EN
      addr_limit = '0;
`endif
      step();
      step();
      rst = 1'b0;
      checks++;
      if ({req_if.req_valid, busy, done, overflow} !== 4'b0000) begin
         errors++;
         $display("FAIL reset_flags: valid/busy/done/ovf=%b want 0000",
                  {req_if.req_valid, busy, done, overflow});
      end
      checks++;
      if (req_if.req_addr !== '0) begin
         errors++;
         $display("FAIL reset_addr: got %h want 0", req_if.req_addr);
      end
      checks++;
      if (issued_cnt !== 32'd0) begin
         errors++;
         $display("FAIL reset_cnt: got %0d want 0", issued_cnt);
      end
   endtask

   task automatic test_basic();
      req_if.req_ready = 1'b1;
      do_start(32'd8);
      checks++;
      if (busy !== 1'b1) begin
         errors++;
         $display("FAIL basic_busy: got %b want 1", busy);
      end
      in_addr = 32'h100;
      for (int k = 0; k < 8; k++) begin
         exp_q.push_back(in_addr);
         step();
         if (k == 0) begin
            checks++;
            if (req_if.req_valid !== 1'b1 || req_if.req_addr !== 32'h100) begin
               errors++;
               $display("FAIL basic_latency: valid=%b addr=%h want 1 00000100",
                        req_if.req_valid, req_if.req_addr);
            end
         end
      end
      for (int i = 0; i < 20 && done !== 1'b1; i++) step();
      checks++;
      if (done !== 1'b1 || busy !== 1'b0) begin
         errors++;
         $display("FAIL basic_done: done=%b busy=%b want 1 0", done, busy);
      end
      checks++;
      if (issued_cnt !== 32'd8) begin
         errors++;
         $display("FAIL basic_cnt: got %0d want 8", issued_cnt);
      end
      checks++;
      if (overflow !== 1'b0) begin
         errors++;
         $display("FAIL basic_ovf: got %b want 0", overflow);
      end
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL basic_left: %0d addresses never issued, want 0", exp_q.size());
      end
   endtask

   task automatic test_overflow();
      req_if.req_ready = 1'b0;
      exp_q.delete();
      do_start(32'd12);
      for (int k = 0; k < 12; k++) begin
         if (k < DEPTH) exp_q.push_back(in_addr);
         step();
      end
      checks++;
      if (overflow !== 1'b1) begin
         errors++;
         $display("FAIL ovf_flag: got %b want 1", overflow);
      end
      checks++;
      if (req_if.req_valid !== 1'b1 || req_if.req_addr !== exp_q[0] || issued_cnt !== 32'd0) begin
         errors++;
         $display("FAIL ovf_head: valid=%b addr=%h cnt=%0d want 1 %h 0",
                  req_if.req_valid, req_if.req_addr, issued_cnt, exp_q[0]);
      end
      req_if.req_ready = 1'b1;
      for (int i = 0; i < 30 && done !== 1'b1; i++) step();
      checks++;
      if (done !== 1'b1 || issued_cnt !== 32'd8) begin
         errors++;
         $display("FAIL ovf_drain: done=%b cnt=%0d want 1 8", done, issued_cnt);
      end
      checks++;
      if (overflow !== 1'b1 || exp_q.size() != 0) begin
         errors++;
         $display("FAIL ovf_sticky: ovf=%b left=%0d want 1 0", overflow, exp_q.size());
      end
   endtask

   task automatic test_full_pop();
      req_if.req_ready = 1'b0;
      exp_q.delete();
      do_start(32'd10);
      for (int k = 0; k < 10; k++) begin
         if (k == DEPTH) req_if.req_ready = 1'b1;
         exp_q.push_back(in_addr);
         step();
      end
      req_if.req_ready = 1'b0;
      checks++;
      if (overflow !== 1'b0 || issued_cnt !== 32'd2) begin
         errors++;
         $display("FAIL fullpop_run: ovf=%b cnt=%0d want 0 2", overflow, issued_cnt);
      end
      checks++;
      if (exp_q.size() != DEPTH) begin
         errors++;
         $display("FAIL fullpop_occ: pending=%0d want %0d", exp_q.size(), DEPTH);
      end
      req_if.req_ready = 1'b1;
      for (int i = 0; i < 30 && done !== 1'b1; i++) step();
      checks++;
      if (done !== 1'b1 || issued_cnt !== 32'd10 || overflow !== 1'b0) begin
         errors++;
         $display("FAIL fullpop_end: done=%b cnt=%0d ovf=%b want 1 10 0", done, issued_cnt, overflow);
      end
   endtask

   task automatic test_zero();
      logic seen_valid;
      seen_valid = 1'b0;
      req_if.req_ready = 1'b1;
      exp_q.delete();
      do_start(32'd0);
      checks++;
      if (done !== 1'b1 || busy !== 1'b0) begin
         errors++;
         $display("FAIL zero_done: done=%b busy=%b want 1 0", done, busy);
      end
      for (int i = 0; i < 6; i++) begin
         if (req_if.req_valid !== 1'b0) seen_valid = 1'b1;
         step();
      end
      checks++;
      if (seen_valid !== 1'b0 || issued_cnt !== 32'd0) begin
         errors++;
         $display("FAIL zero_quiet: valid_seen=%b cnt=%0d want 0 0", seen_valid, issued_cnt);
      end
   endtask

   task automatic test_rst_mid();
      logic seen_valid;
      seen_valid = 1'b0;
      req_if.req_ready = 1'b0;
      exp_q.delete();
      do_start(32'd5);
      for (int k = 0; k < 5; k++) begin
         exp_q.push_back(in_addr);
         if (k == 2) begin
            start    = 1'b1;
            num_reqs = 32'd0;
         end
         step();
         start = 1'b0;
         if (k == 2) begin
            checks++;
            if (busy !== 1'b1 || done !== 1'b0) begin
               errors++;
               $display("FAIL mid_start: busy=%b done=%b want 1 0", busy, done);
            end
         end
      end
      step();
      checks++;
      if (busy !== 1'b1 || req_if.req_valid !== 1'b1 || req_if.req_addr !== exp_q[0]) begin
         errors++;
         $display("FAIL mid_drain: busy=%b valid=%b addr=%h want 1 1 %h",
                  busy, req_if.req_valid, req_if.req_addr, exp_q[0]);
      end
      rst = 1'b1;
      step();
      checks++;
      if (req_if.req_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || issued_cnt !== 32'd0) begin
         errors++;
         $display("FAIL mid_rst: valid=%b busy=%b done=%b cnt=%0d want 0 0 0 0",
                  req_if.req_valid, busy, done, issued_cnt);
      end
      rst = 1'b0;
      exp_q.delete();
      req_if.req_ready = 1'b1;
      for (int i = 0; i < 6; i++) begin
         if (req_if.req_valid !== 1'b0 || busy !== 1'b0) seen_valid = 1'b1;
         step();
      end
      checks++;
      if (seen_valid !== 1'b0) begin
         errors++;
         $display("FAIL post_rst_quiet: activity=%b want 0", seen_valid);
      end
   endtask

`ifdef ADDR_REQ_BOUNDS_CHECK_EN
   task automatic test_bounds();
      req_if.req_ready = 1'b1;
      exp_q.delete();
      addr_limit = 32'h104;
      do_start(32'd8);
      in_addr = 32'h100;
      for (int k = 0; k < 8; k++) begin
         if (in_addr < 32'h104) exp_q.push_back(in_addr);
         step();
      end
      for (int i = 0; i < 20 && done !== 1'b1; i++) step();
      checks++;
      if (done !== 1'b1 || issued_cnt !== 32'd4) begin
         errors++;
         $display("FAIL bounds_cnt: done=%b cnt=%0d want 1 4", done, issued_cnt);
      end
      checks++;
      if (bounds_err !== 1'b1 || exp_q.size() != 0) begin
         errors++;
         $display("FAIL bounds_err: err=%b left=%0d want 1 0", bounds_err, exp_q.size());
      end
   endtask
`endif

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_basic();
      test_overflow();
      test_full_pop();
      test_zero();
      test_rst_mid();
`ifdef ADDR_REQ_BOUNDS_CHECK_EN
      test_bounds();
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/addr_req_issuer.md
ADDR_REQ_ISSUER -- requirements
Module: addr_req_issuer

Interface
REQ-001 SHALL have parameter DEPTH, default 8, meaning FIFO entries (power of two, 2..64).
REQ-002 SHALL have parameter AW, default 32, meaning address width.
REQ-003 SHALL have port clk  input  1  sole clock, rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port start  input  1  one-cycle pulse that begins a run.
REQ-006 SHALL have port num_reqs  input  32  addresses to capture per run, sampled on start.
REQ-007 SHALL have port in_addr  input  AW  free-running address from the address-generator stage, one new value per cycle, no stall.
REQ-008 SHALL have port req_valid  output  1  memory read request valid.
REQ-009 SHALL have port req_ready  input  1  memory read request accepted when high with req_valid.
REQ-010 SHALL have port req_addr  output  AW  memory read address.
REQ-011 SHALL have ports busy, done, overflow  output  1 each; and issued_cnt  output  32  requests accepted this run.

Function
REQ-012 SHALL implement states IDLE, RUN, DRAIN, DONE.
REQ-013 SHALL, on start in IDLE or DONE, latch num_reqs, clear capture count, issued_cnt, overflow, and flush the FIFO; go to RUN, or to DONE if num_reqs==0; start in RUN/DRAIN SHALL be ignored.
REQ-014 SHALL, in RUN, push in_addr every cycle until capture count equals latched num_reqs, then go to DRAIN the next cycle.
REQ-015 SHALL count a push as captured even if dropped; a push into a full FIFO with no same-cycle pop SHALL be dropped and set overflow sticky until next start or rst.
REQ-016 SHALL accept a push when full if a pop occurs in the same cycle (no overflow).
REQ-017 SHALL pop on req_valid && req_ready and increment issued_cnt (32-bit, wraps).
REQ-018 SHALL assert req_valid exactly when the FIFO is non-empty; req_addr SHALL be the head entry, stable while req_valid && !req_ready.
REQ-019 SHALL have latency of one cycle: an address pushed into an empty FIFO at edge t is presented at req_addr after edge t (visible in cycle t+1).
REQ-020 SHALL move DRAIN -> DONE when the FIFO is empty; DONE holds until start.
REQ-021 SHALL drive busy=1 in RUN and DRAIN, done=1 only in DONE.

Reset
REQ-022 SHALL, on rst (overriding start and any handshake), enter IDLE, empty FIFO, and drive req_valid=0, req_addr=0, busy=0, done=0, overflow=0, issued_cnt=0 from the following cycle.
REQ-023 SHALL discard in-flight entries on rst mid-run; no request SHALL be issued after reset until a new start.

Configuration
REQ-024 SHALL support macro ADDR_REQ_BOUNDS_CHECK_EN: when defined, adds input addr_limit (AW) sampled on start and output bounds_err (1); captured addresses >= addr_limit are dropped (still counted as captured) and set bounds_err sticky until start/rst.
REQ-025 SHALL, without ADDR_REQ_BOUNDS_CHECK_EN, have no addr_limit/bounds_err ports and push every captured address.

Structure
REQ-026 SHALL place the state enum (IDLE, RUN, DRAIN, DONE) and default DEPTH/AW constants in shared package addr_gen_pkg.
REQ-027 SHALL implement buffering in one sub-module addr_fifo (synchronous FIFO, push/pop/full/empty/head, same-cycle push+pop when full allowed).

Verification
REQ-028 SHALL cover: num_reqs=8, in_addr=0x100+cycle, req_ready=1 -> req_addr 0x100..0x107 in order, issued_cnt=8, done=1, overflow=0.
REQ-029 SHALL cover: DEPTH=8, num_reqs=12, req_ready=0 throughout RUN -> first 8 buffered, overflow=1, then req_ready=1 drains 8 entries, issued_cnt=8, DONE.
REQ-030 SHALL cover: FIFO full, req_ready=1 same cycle as push -> no overflow, occupancy stays 8.
REQ-031 SHALL cover: num_reqs=0 start -> DONE next cycle, req_valid never asserted.
REQ-032 SHALL cover: rst asserted in DRAIN with 5 entries -> next cycle req_valid=0, state IDLE, issued_cnt=0; start mid-RUN ignored.
REQ-033 SHALL cover (ADDR_REQ_BOUNDS_CHECK_EN): addr_limit=0x104, addrs 0x100..0x107 -> only 0x100..0x103 issued, bounds_err=1.
